// File: rtl/serial_byte_subtractor.sv
// serial_byte_subtractor: LSB-first multi-byte unsigned subtract with a held borrow and whole-word zero detect.
// Latency: 1 cycle from accepted beat to output register; sustains one beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output freezes borrow, zero accumulator and state.
module serial_byte_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_diff,
    output logic         out_last,
    output logic         out_borrow,
    output logic         out_zero,
    output logic         out_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           borrow_q;
    logic           zacc_q;

    logic           accept;
    logic           start_beat;
    logic           frame_err;
    logic           bin;
    logic [W:0]     sub_res;
    logic [W-1:0]   diff_nxt;
    logic           borrow_nxt;
    logic           zacc_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A first-flagged beat mid-word abandons the word, so it restarts exactly like an idle start.
    always_comb begin
        start_beat = 1'b1;
        frame_err  = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                start_beat = 1'b1;
                frame_err  = !in_first;
            end
            BUSY: begin
                start_beat = in_first;
                frame_err  = in_first;
            end
            default: begin
                start_beat = 1'b1;
                frame_err  = 1'b0;
            end
        endcase

        bin        = start_beat ? 1'b0 : borrow_q;
        sub_res    = {1'b0, minuend} - {1'b0, subtrahend} - {{W{1'b0}}, bin};
        diff_nxt   = sub_res[W-1:0];
        borrow_nxt = sub_res[W];
        zacc_nxt   = (start_beat ? 1'b1 : zacc_q) & (diff_nxt == '0);

        if (accept) begin
            state_nxt = in_last ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_last   <= 1'b0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
            borrow_q   <= 1'b0;
            zacc_q     <= 1'b1;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_diff   <= diff_nxt;
            out_last   <= in_last;
            out_borrow <= borrow_nxt;
            out_zero   <= zacc_nxt;
            out_err    <= frame_err;
            borrow_q   <= borrow_nxt;
            zacc_q     <= zacc_nxt;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// Bench for serial_byte_subtractor: directed literal cases plus random traffic against a whole-word arithmetic model.
module tb_serial_byte_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         in_last;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_last;
    logic         out_borrow;
    logic         out_zero;
    logic         out_err;

    serial_byte_subtractor #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_last   (out_last),
        .out_borrow (out_borrow),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: accumulate the word's operands as whole integers and read each result byte off the full difference.
    logic            exp_valid = 1'b0;
    logic [7:0]      exp_diff  = 8'h00;
    logic            exp_last  = 1'b0;
    logic            exp_borrow = 1'b0;
    logic            exp_zero  = 1'b0;
    logic            exp_err   = 1'b0;
    bit              m_in_word = 1'b0;
    int              m_n = 0;
    longint unsigned m_val = 0;
    longint unsigned s_val = 0;
    bit              acc_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task model_beat();
        bit              start;
        longint unsigned mask;
        longint unsigned d;
        start = !m_in_word || in_first;
        exp_err = m_in_word ? in_first : !in_first;
        if (start) begin
            m_n   = 0;
            m_val = 0;
            s_val = 0;
        end
        m_val = m_val | (64'(minuend) << (8 * m_n));
        s_val = s_val | (64'(subtrahend) << (8 * m_n));
        m_n++;
        mask = (m_n >= 8) ? '1 : ((64'd1 << (8 * m_n)) - 64'd1);
        d = (m_val - s_val) & mask;
        exp_diff   = 8'(d >> (8 * (m_n - 1)));
        exp_borrow = (m_val < s_val);
        exp_zero   = (m_val == s_val);
        exp_last   = in_last;
        exp_valid  = 1'b1;
        m_in_word  = !in_last;
    endtask

    // Called at posedge+1; inputs must already be set for the coming edge.
    task step();
        bit acc;
        acc = in_valid && (!exp_valid || out_ready);
        @(posedge clk);
        if (acc) model_beat();
        else if (out_ready) exp_valid = 1'b0;
        acc_last = acc;
        #1;
    endtask

    task beat(input bit f, input bit l, input logic [7:0] m, input logic [7:0] s);
        in_valid   = 1'b1;
        in_first   = f;
        in_last    = l;
        minuend    = m;
        subtrahend = s;
        out_ready  = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("in_ready", in_ready, !exp_valid || out_ready);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("out_diff", out_diff, exp_diff);
                chk("out_last", out_last, exp_last);
                chk("out_borrow", out_borrow, exp_borrow);
                chk("out_zero", out_zero, exp_zero);
                chk("out_err", out_err, exp_err);
            end
        end
    end

    initial begin
        int pos;
        int len;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        out_ready  = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_diff", out_diff, 8'h00);
        chk("rst_out_flags", {out_last, out_borrow, out_zero, out_err}, 4'b0000);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // single-beat word
        beat(1'b1, 1'b1, 8'h50, 8'h30);
        chk("single_diff", out_diff, 8'h20);
        chk("single_flags", {out_valid, out_last, out_borrow, out_zero, out_err}, 5'b11000);
        chk("m_single_diff", exp_diff, 8'h20);

        // 0x1200 - 0x0001
        beat(1'b1, 1'b0, 8'h00, 8'h01);
        chk("two_b0_diff", out_diff, 8'hFF);
        chk("two_b0_borrow", out_borrow, 1'b1);
        chk("m_two_b0_borrow", exp_borrow, 1'b1);
        beat(1'b0, 1'b1, 8'h12, 8'h00);
        chk("two_b1_diff", out_diff, 8'h11);
        chk("two_b1_borrow_last", {out_borrow, out_last}, 2'b01);
        chk("m_two_b1_diff", exp_diff, 8'h11);

        // 0x3434 - 0x3434
        beat(1'b1, 1'b0, 8'h34, 8'h34);
        chk("eq_b0_diff", out_diff, 8'h00);
        beat(1'b0, 1'b1, 8'h34, 8'h34);
        chk("eq_b1_diff", out_diff, 8'h00);
        chk("eq_zero_borrow", {out_zero, out_borrow}, 2'b10);
        chk("m_eq_zero", exp_zero, 1'b1);

        // 0x0001 - 0x0002
        beat(1'b1, 1'b0, 8'h01, 8'h02);
        chk("neg_b0_diff", out_diff, 8'hFF);
        beat(1'b0, 1'b1, 8'h00, 8'h00);
        chk("neg_b1_diff", out_diff, 8'hFF);
        chk("neg_borrow_zero", {out_borrow, out_zero}, 2'b10);
        chk("m_neg_borrow", exp_borrow, 1'b1);

        // backpressure mid-word: 0x443310 - 0x441120
        beat(1'b1, 1'b0, 8'h10, 8'h20);
        in_valid   = 1'b1;
        in_first   = 1'b0;
        in_last    = 1'b0;
        minuend    = 8'h33;
        subtrahend = 8'h11;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_diff_hold", out_diff, 8'hF0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_diff", out_diff, 8'h21);
        beat(1'b0, 1'b1, 8'h44, 8'h44);
        chk("bp_last_diff", out_diff, 8'h00);
        chk("bp_last_flags", {out_last, out_borrow, out_zero}, 3'b100);

        // framing
        beat(1'b1, 1'b0, 8'h00, 8'h01);
        beat(1'b1, 1'b1, 8'h05, 8'h01);
        chk("frm_busy_diff", out_diff, 8'h04);
        chk("frm_busy_err", out_err, 1'b1);
        chk("m_frm_busy_err", exp_err, 1'b1);
        beat(1'b0, 1'b1, 8'h00, 8'h01);
        chk("frm_idle_diff", out_diff, 8'hFF);
        chk("frm_idle_err", out_err, 1'b1);
        beat(1'b1, 1'b1, 8'h09, 8'h02);
        chk("frm_clear_err", {out_err, out_diff}, 9'h007);

        // async reset mid-word
        beat(1'b1, 1'b0, 8'h00, 8'h01);
        chk("rst_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_diff", out_diff, 8'h00);
        exp_valid = 1'b0;
        m_in_word = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(1'b1, 1'b1, 8'h00, 8'h00);
        chk("post_rst_diff", out_diff, 8'h00);
        chk("post_rst_flags", {out_borrow, out_zero, out_err}, 3'b010);

        // random traffic
        pos = 0;
        len = $urandom_range(1, 6);
        acc_last = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (acc_last) begin
                in_first   = (pos == 0) ^ ($urandom_range(0, 31) == 0);
                in_last    = (pos == len - 1);
                minuend    = 8'($urandom);
                subtrahend = ($urandom_range(0, 2) == 0) ? minuend : 8'($urandom);
            end
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (acc_last) begin
                if (in_last) begin
                    pos = 0;
                    len = $urandom_range(1, 6);
                end else begin
                    pos++;
                end
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_byte_subtractor.md
Name: serial_byte_subtractor

Overview:
- Multi-byte unsigned subtractor, streamed one byte per beat, least significant byte first.
- Borrow is held in a register between beats, so one 8-bit datapath handles operands of any byte length.
- Counterpart to the team's combinational byte adders: it computes differences and unsigned compare results for wide words.
- Sits between a byte-stream producer and consumer, with valid/ready handshakes on both sides.

Parameters:
W, 8, data width per beat in bits (all datapath widths below are W; spec values assume 8).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept a beat this cycle
in_first  input  1  beat is least significant byte of a word
in_last  input  1  beat is most significant byte of a word
minuend  input  W  minuend byte
subtrahend  input  W  subtrahend byte
out_valid  output  1  output beat present
out_ready  input  1  consumer accepts output beat
out_diff  output  W  difference byte
out_last  output  1  output beat closes a word
out_borrow  output  1  final borrow (minuend < subtrahend); meaningful only when out_last=1
out_zero  output  1  whole-word difference is zero; meaningful only when out_last=1
out_err  output  1  framing error seen on the beat that produced this output

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - out_valid, out_diff, out_last, out_borrow, out_zero and out_err = 0.
  - Borrow register = 0, zero accumulator = 1, state = IDLE.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). It is 1 out of reset.
  - A beat is accepted when in_valid && in_ready. Output beat handed off when out_valid && out_ready.
  - Single output register, 1-cycle latency: an accepted beat appears on the outputs the next cycle.
  - Full throughput: one beat per cycle when out_ready is held at 1.
  - out_valid clears only on hand-off with no new beat accepted.
  - Output fields stay stable while out_valid && !out_ready.
- Arithmetic, per accepted beat:
  - bin = 0 if the beat starts a word, else borrow register.
  - {b, d} = {1'b0, minuend} - {1'b0, subtrahend} - bin, a (W+1)-bit result. d = low W bits; b = bit W.
  - out_diff <= d. Borrow register <= b. out_borrow <= b.
  - zacc = (starts word ? 1 : zero accumulator) & (d == 0). Zero accumulator <= zacc. out_zero <= zacc.
  - out_last <= in_last.
- State machine (the beat that "starts a word" is defined here):
  - IDLE: an accepted beat starts a word. in_last=1 → stay IDLE (single-beat word); in_last=0 → BUSY.
  - BUSY: an accepted beat continues the word. in_last=1 → IDLE.
  - The state only advances on accepted beats.
- Framing errors:
  - Beat in IDLE with in_first=0: treated as a start (bin=0, accumulator restarted). out_err <= 1.
  - Beat in BUSY with in_first=1: current word abandoned and the beat treated as a start (bin=0). out_err <= 1. The next state follows the IDLE rules.
  - Otherwise out_err <= 0. out_err travels with its output beat and is not sticky.
- Boundaries:
  - 0x00 - 0xFF with bin=1 gives d=0x00, b=1.
  - Borrow never leaks across words, because a start beat always forces bin=0.
  - Backpressure (out_valid && !out_ready) blocks acceptance, so the borrow register and state are frozen.
  - Reset mid-word discards the partial word, the borrow and any pending output beat.

Test Plan:
- Single-beat word: first=last=1, 0x50 - 0x30 → out_diff=0x20, out_borrow=0, out_zero=0, out_last=1, out_err=0, one cycle after accept.
- Two-beat word 0x1200 - 0x0001: beat0 0x00-0x01 → diff 0xFF, borrow 1; beat1 0x12-0x00 → diff 0x11, out_borrow=0, out_last=1.
- Equal and negative words:
  - 0x3434 - 0x3434 over 2 beats → diffs 0x34-0x34=0x00 twice, last beat out_zero=1, out_borrow=0.
  - 0x0001 - 0x0002 over 2 beats → diffs 0xFF, 0xFF, last beat out_borrow=1, out_zero=0.
- Backpressure: hold out_ready=0 for 3 cycles mid-word with in_valid=1 → in_ready=0, out_diff stable, no beat lost. Release → remaining diffs correct, 1 beat/cycle thereafter.
- Framing: after beat0 of a word (borrow=1), send in_first=1 beat 0x05-0x01 → out_diff=0x04 (bin forced 0), out_err=1. A beat with in_first=0 in IDLE → out_err=1, bin=0.
- Async reset asserted mid-word with out_valid=1 → out_valid=0 immediately. The next first beat 0x00-0x00 gives diff 0x00, borrow 0, out_zero=1.
